// File: rtl/car_motion_ctl.sv
// Player car kinematics: once per video frame (vblnk rising edge) updates speed,
// drive state, lap counter and the car sprite's top-left screen position.
module car_motion_ctl #(
    parameter int SCREEN_W   = 1024,
    parameter int SCREEN_H   = 768,
    parameter int CAR_W      = 64,
    parameter int CAR_H      = 64,
    parameter int X_INIT     = 480,
    parameter int Y_INIT     = 600,
    parameter int MAX_SPEED  = 8,
    parameter int ACCEL_DIV  = 4,
    parameter int STEER_STEP = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        enable,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic [3:0]  speed,
    output logic [7:0]  lap_count,
    output logic [2:0]  drive_state,
    output logic        frame_tick
);

    localparam logic [10:0] X_MAX    = 11'(SCREEN_W - CAR_W);
    localparam logic [10:0] Y_SPAN   = 11'(SCREEN_H - CAR_H);
    localparam logic [10:0] X_RST    = 11'(X_INIT);
    localparam logic [10:0] Y_RST    = 11'(Y_INIT);
    localparam logic [10:0] STEP     = 11'(STEER_STEP);
    localparam logic [3:0]  SPD_MAX  = 4'(MAX_SPEED);
    localparam logic [3:0]  DIV_LAST = 4'(ACCEL_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEL  = 3'd1,
        ST_CRUISE = 3'd2,
        ST_COAST  = 3'd3,
        ST_BRAKE  = 3'd4
    } drive_t;

    // Which pedal class the driver is applying; a change restarts the divider.
    typedef enum logic [1:0] {
        KEY_NONE = 2'd0,
        KEY_THR  = 2'd1,
        KEY_BRK  = 2'd2
    } key_cls_t;

    function automatic logic [3:0] spd_sub_sat(input logic [3:0] s, input logic [3:0] d);
        return (s >= d) ? s - d : 4'd0;
    endfunction

    function automatic logic [3:0] spd_inc_sat(input logic [3:0] s);
        return (s >= SPD_MAX) ? SPD_MAX : s + 4'd1;
    endfunction

    function automatic logic [10:0] x_left_sat(input logic [10:0] x);
        return (x >= STEP) ? x - STEP : 11'd0;
    endfunction

    function automatic logic [10:0] x_right_sat(input logic [10:0] x);
        return (x >= X_MAX - STEP) ? X_MAX : x + STEP;
    endfunction

    logic [10:0] r_xpos;
    logic [10:0] r_ypos;
    logic [3:0]  r_speed;
    logic [7:0]  r_lap;
    drive_t      r_state;
    logic [3:0]  r_div;
    key_cls_t    r_cls;
    logic        r_vblnk_d;
    logic        r_frame_tick;

    logic        w_tick;
    key_cls_t    w_cls;
    logic [3:0]  w_div_eff;
    logic        w_div_hit;
    logic [3:0]  w_speed_nxt;
    logic [3:0]  w_div_nxt;
    drive_t      w_state_nxt;
    logic [10:0] w_speed_ext;
    logic        w_y_wrap;
    logic [10:0] w_ypos_nxt;
    logic [7:0]  w_lap_nxt;
    logic [10:0] w_xpos_nxt;

    assign w_tick = vblnk & ~r_vblnk_d;

    // Speed, divider and drive-state update for the current key class.
    always_comb begin
        w_cls       = key_down ? KEY_BRK : (key_up ? KEY_THR : KEY_NONE);
        w_div_eff   = (w_cls == r_cls) ? r_div : 4'd0;
        w_div_hit   = (w_div_eff == DIV_LAST);
        w_speed_nxt = r_speed;
        w_div_nxt   = 4'd0;
        w_state_nxt = ST_IDLE;
        case (w_cls)
            KEY_BRK: begin
                w_speed_nxt = spd_sub_sat(r_speed, 4'd2);
                w_state_nxt = (w_speed_nxt == 4'd0) ? ST_IDLE : ST_BRAKE;
            end
            KEY_THR: begin
                if (w_div_hit) begin
                    w_speed_nxt = spd_inc_sat(r_speed);
                end else begin
                    w_div_nxt = w_div_eff + 4'd1;
                end
                w_state_nxt = (w_speed_nxt == SPD_MAX) ? ST_CRUISE : ST_ACCEL;
            end
            default: begin
                if (w_div_hit) begin
                    w_speed_nxt = spd_sub_sat(r_speed, 4'd1);
                end else begin
                    w_div_nxt = w_div_eff + 4'd1;
                end
                w_state_nxt = (w_speed_nxt != 4'd0) ? ST_COAST : ST_IDLE;
            end
        endcase
    end

    // Position moves by the speed held before this frame's speed update.
    always_comb begin
        w_speed_ext = {7'd0, r_speed};
        w_y_wrap    = (r_ypos < w_speed_ext);
        w_ypos_nxt  = w_y_wrap ? r_ypos + Y_SPAN - w_speed_ext : r_ypos - w_speed_ext;
        w_lap_nxt   = w_y_wrap ? r_lap + 8'd1 : r_lap;
        w_xpos_nxt  = r_xpos;
        if (r_speed != 4'd0) begin
            if (key_left && !key_right) begin
                w_xpos_nxt = x_left_sat(r_xpos);
            end else if (key_right && !key_left) begin
                w_xpos_nxt = x_right_sat(r_xpos);
            end
        end
    end

    // Frame-rate state machine; disable forces a stop every cycle, reset wins over all.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_xpos       <= X_RST;
            r_ypos       <= Y_RST;
            r_speed      <= 4'd0;
            r_lap        <= 8'd0;
            r_state      <= ST_IDLE;
            r_div        <= 4'd0;
            r_cls        <= KEY_NONE;
            r_vblnk_d    <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_vblnk_d    <= vblnk;
            r_frame_tick <= enable & w_tick;
            if (!enable) begin
                r_speed <= 4'd0;
                r_div   <= 4'd0;
                r_state <= ST_IDLE;
            end else if (w_tick) begin
                r_speed <= w_speed_nxt;
                r_div   <= w_div_nxt;
                r_state <= w_state_nxt;
                r_cls   <= w_cls;
                r_xpos  <= w_xpos_nxt;
                r_ypos  <= w_ypos_nxt;
                r_lap   <= w_lap_nxt;
            end
        end
    end

    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign speed       = r_speed;
    assign lap_count   = r_lap;
    assign drive_state = r_state;
    assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_car_motion_ctl.sv
// Bench for car_motion_ctl: directed scenarios plus randomized frames, all
// compared against a frame-level behavioural model of the car.
module tb_car_motion_ctl;

    localparam int ACCEL_DIV = 4;
    localparam int MAXS      = 8;
    localparam int Y_SPAN    = 704;
    localparam int X_MAX     = 960;
    localparam int STEP      = 4;

    logic        pclk = 1'b0;
    logic        rst, vblnk, enable, key_up, key_down, key_left, key_right;
    logic [10:0] xpos, ypos;
    logic [3:0]  speed;
    logic [7:0]  lap_count;
    logic [2:0]  drive_state;
    logic        frame_tick;
    logic [36:0] dut_vec;
    logic [36:0] rst_vec;

    int checks = 0;
    int errors = 0;
    int ft_count;
    bit ft_first;

    // model state
    int m_x, m_y, m_spd, m_lap, m_st, m_div, m_cls;
    bit m_vd;

    car_motion_ctl dut (
        .pclk(pclk), .rst(rst), .vblnk(vblnk), .enable(enable),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .xpos(xpos), .ypos(ypos), .speed(speed), .lap_count(lap_count),
        .drive_state(drive_state), .frame_tick(frame_tick)
    );

    always #5 pclk = ~pclk;

    assign dut_vec = {xpos, ypos, speed, lap_count, drive_state};
    assign rst_vec = {11'd480, 11'd600, 4'd0, 8'd0, 3'd0};

    function automatic logic [36:0] exp_vec();
        return {11'(m_x), 11'(m_y), 4'(m_spd), 8'(m_lap), 3'(m_st)};
    endfunction

    function automatic void model_reset();
        m_x = 480; m_y = 600; m_spd = 0; m_lap = 0; m_st = 0;
        m_div = 0; m_cls = 0; m_vd = 1'b1;
    endfunction

    // One enabled frame: pedal rules, then movement by the pre-update speed.
    function automatic void model_frame();
        int cls, d, old;
        cls = key_down ? 2 : (key_up ? 1 : 0);
        d = (cls == m_cls) ? m_div : 0;
        m_cls = cls;
        old = m_spd;
        if (cls == 2) begin
            m_spd = (old > 2) ? old - 2 : 0;
            m_div = 0;
            m_st = (m_spd == 0) ? 0 : 4;
        end else begin
            if (d == ACCEL_DIV - 1) begin
                m_div = 0;
                if (cls == 1) m_spd = (old < MAXS) ? old + 1 : MAXS;
                else          m_spd = (old > 0) ? old - 1 : 0;
            end else begin
                m_div = d + 1;
            end
            if (cls == 1) m_st = (m_spd == MAXS) ? 2 : 1;
            else          m_st = (m_spd > 0) ? 3 : 0;
        end
        if (m_y >= old) begin
            m_y = m_y - old;
        end else begin
            m_y = m_y + Y_SPAN - old;
            m_lap = (m_lap + 1) % 256;
        end
        if (old > 0) begin
            if (key_left && !key_right)      m_x = (m_x > STEP) ? m_x - STEP : 0;
            else if (key_right && !key_left) m_x = (m_x + STEP < X_MAX) ? m_x + STEP : X_MAX;
        end
    endfunction

    task automatic edge_step();
        bit tick;
        @(posedge pclk);
        tick = vblnk && !m_vd;
        if (rst) begin
            model_reset();
        end else begin
            if (!enable) begin
                m_spd = 0; m_div = 0; m_st = 0;
            end else if (tick) begin
                model_frame();
            end
            m_vd = vblnk;
        end
        #1;
        if (frame_tick === 1'b1) ft_count++;
    endtask

    task automatic run_frame(input int hi, input int lo);
        ft_count = 0;
        vblnk = 1'b1;
        edge_step();
        ft_first = (frame_tick === 1'b1);
        repeat (hi - 1) edge_step();
        vblnk = 1'b0;
        repeat (lo) edge_step();
    endtask

    task automatic test_reset();
        rst = 1'b1; vblnk = 1'b0; enable = 1'b1;
        key_up = 1'b1; key_down = 1'b0; key_left = 1'b0; key_right = 1'b1;
        model_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(3, 3);
            checks++;
            if (dut_vec !== rst_vec) begin
                errors++; $display("FAIL reset_vals f%0d: got %h want %h", f, dut_vec, rst_vec);
            end
            checks++;
            if (ft_count != 0) begin
                errors++; $display("FAIL reset_tick f%0d: got %0d pulses want 0", f, ft_count);
            end
        end
        // release reset while vblnk is already high: no tick may follow
        vblnk = 1'b1;
        edge_step();
        rst = 1'b0;
        ft_count = 0;
        repeat (3) edge_step();
        checks++;
        if (ft_count != 0 || dut_vec !== rst_vec) begin
            errors++; $display("FAIL reset_release: pulses %0d vec %h want 0 %h", ft_count, dut_vec, rst_vec);
        end
    endtask

    task automatic test_throttle();
        int es, est;
        key_up = 1'b1; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        vblnk = 1'b0;
        edge_step();
        for (int n = 1; n <= 40; n++) begin
            run_frame(1, 1);
            es = (n / 4 < MAXS) ? n / 4 : MAXS;
            est = (es == MAXS) ? 2 : 1;
            checks++;
            if (speed !== 4'(es) || drive_state !== 3'(est)) begin
                errors++; $display("FAIL thr_speed t%0d: got %0d/%0d want %0d/%0d", n, speed, drive_state, es, est);
            end
            checks++;
            if (!ft_first || ft_count != 1) begin
                errors++; $display("FAIL thr_ftick t%0d: first %0d count %0d want 1 1", n, ft_first, ft_count);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL thr_model t%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_brake();
        int spd_tab [5] = '{6, 4, 2, 0, 0};
        int st_tab  [5] = '{4, 4, 4, 0, 0};
        int drop    [5] = '{8, 6, 4, 2, 0};
        int y0;
        key_up = 1'b1; key_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            y0 = m_y;
            run_frame(2, 1);
            checks++;
            if (speed !== 4'(spd_tab[i]) || drive_state !== 3'(st_tab[i])) begin
                errors++; $display("FAIL brake_speed %0d: got %0d/%0d want %0d/%0d", i, speed, drive_state, spd_tab[i], st_tab[i]);
            end
            checks++;
            if (ypos !== 11'(y0 - drop[i])) begin
                errors++; $display("FAIL brake_ypos %0d: got %0d want %0d", i, ypos, y0 - drop[i]);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL brake_model %0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_wrap_lap();
        int y0, lap0, s0;
        bit done = 1'b0;
        key_up = 1'b1; key_down = 1'b0;
        for (int f = 0; f < 24000 && !done; f++) begin
            y0 = m_y; lap0 = m_lap; s0 = m_spd;
            run_frame(1, 1);
            if (y0 < s0) begin
                checks++;
                if (ypos !== 11'(y0 + Y_SPAN - s0)) begin
                    errors++; $display("FAIL wrap_ypos f%0d: got %0d want %0d", f, ypos, y0 + Y_SPAN - s0);
                end
                checks++;
                if (lap_count !== 8'((lap0 + 1) % 256)) begin
                    errors++; $display("FAIL wrap_lap f%0d: got %0d want %0d", f, lap_count, (lap0 + 1) % 256);
                end
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL wrap_model f%0d: got %h want %h", f, dut_vec, exp_vec());
                end
                if (lap0 == 255) begin
                    done = 1'b1;
                    checks++;
                    if (lap_count !== 8'd0) begin
                        errors++; $display("FAIL lap_rollover: got %0d want 0", lap_count);
                    end
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL lap_timeout: lap %0d never rolled over", lap_count);
        end
    endtask

    task automatic test_steer();
        key_up = 1'b1; key_down = 1'b0; key_left = 1'b0; key_right = 1'b1;
        for (int f = 0; f < 125; f++) begin
            run_frame(1, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL steer_r_model f%0d: got %h want %h", f, dut_vec, exp_vec());
            end
        end
        checks++;
        if (xpos !== 11'd960) begin
            errors++; $display("FAIL steer_right_edge: got %0d want 960", xpos);
        end
        key_right = 1'b0; key_left = 1'b1;
        for (int f = 0; f < 245; f++) run_frame(1, 1);
        checks++;
        if (xpos !== 11'd0) begin
            errors++; $display("FAIL steer_left_edge: got %0d want 0", xpos);
        end
        key_left = 1'b0; key_right = 1'b1;
        for (int f = 0; f < 10; f++) run_frame(1, 1);
        checks++;
        if (xpos !== 11'd40) begin
            errors++; $display("FAIL steer_move: got %0d want 40", xpos);
        end
        key_right = 1'b0; key_up = 1'b0; key_down = 1'b1;
        for (int f = 0; f < 4; f++) run_frame(1, 1);
        checks++;
        if (speed !== 4'd0) begin
            errors++; $display("FAIL steer_stop: got speed %0d want 0", speed);
        end
        key_down = 1'b0; key_left = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 1);
            checks++;
            if (xpos !== 11'd40) begin
                errors++; $display("FAIL steer_at_rest f%0d: got %0d want 40", f, xpos);
            end
        end
        key_left = 1'b0;
    endtask

    task automatic test_vblnk_hold();
        key_up = 1'b1;
        for (int f = 0; f < 8; f++) run_frame(1, 1);
        run_frame(500, 2);
        checks++;
        if (ft_count != 1) begin
            errors++; $display("FAIL vblnk_hold: got %0d pulses want 1", ft_count);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL vblnk_hold_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_enable_drop();
        int x0, y0;
        key_up = 1'b1; key_down = 1'b0;
        for (int f = 0; f < 60 && m_spd != MAXS; f++) run_frame(1, 1);
        key_down = 1'b1;
        run_frame(1, 1);
        checks++;
        if (speed !== 4'd6) begin
            errors++; $display("FAIL en_setup: got speed %0d want 6", speed);
        end
        key_down = 1'b0;
        x0 = m_x; y0 = m_y;
        enable = 1'b0;
        edge_step();
        checks++;
        if (speed !== 4'd0 || drive_state !== 3'd0 || xpos !== 11'(x0) || ypos !== 11'(y0)) begin
            errors++; $display("FAIL en_drop: got s%0d st%0d x%0d y%0d want 0 0 %0d %0d", speed, drive_state, xpos, ypos, x0, y0);
        end
        for (int f = 0; f < 3; f++) begin
            run_frame(2, 2);
            checks++;
            if (ft_count != 0 || dut_vec !== exp_vec() || xpos !== 11'(x0)) begin
                errors++; $display("FAIL en_hold f%0d: pulses %0d got %h want %h", f, ft_count, dut_vec, exp_vec());
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_tick();
        key_up = 1'b1; key_right = 1'b1;
        for (int f = 0; f < 6; f++) run_frame(1, 1);
        vblnk = 1'b1; rst = 1'b1;
        edge_step();
        checks++;
        if (dut_vec !== rst_vec || frame_tick !== 1'b0) begin
            errors++; $display("FAIL rst_tick: got %h ft %0d want %h 0", dut_vec, frame_tick, rst_vec);
        end
        rst = 1'b0; vblnk = 1'b0;
        edge_step();
        checks++;
        if (dut_vec !== rst_vec || frame_tick !== 1'b0) begin
            errors++; $display("FAIL rst_tick_after: got %h ft %0d want %h 0", dut_vec, frame_tick, rst_vec);
        end
        key_right = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                key_up    = ($urandom_range(0, 9) < 6);
                key_down  = ($urandom_range(0, 9) < 2);
                key_left  = ($urandom_range(0, 9) < 3);
                key_right = ($urandom_range(0, 9) < 3);
            end
            enable = ($urandom_range(0, 19) != 0);
            run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            checks++;
            if (ft_count != (enable ? 1 : 0)) begin
                errors++; $display("FAIL rand_ftick f%0d: got %0d want %0d", f, ft_count, enable ? 1 : 0);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL rand_model f%0d: got %h want %h", f, dut_vec, exp_vec());
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_throttle();
        test_brake();
        test_wrap_lap();
        test_steer();
        test_vblnk_hold();
        test_enable_drop();
        test_reset_tick();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
